// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: round-robin between ALU (A) and load (B)
// writebacks, with a multi-cycle clear sweep that overrides both requesters.
module regfile_wb_arbiter #(
    parameter logic [31:0] CLR_VALUE      = 32'h0000_0000,
    parameter logic [4:0]  FIRST_CLR_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        A_Req,
    input  logic [4:0]  A_Addr,
    input  logic [31:0] A_Data,
    output logic        A_Gnt,
    input  logic        B_Req,
    input  logic [4:0]  B_Addr,
    input  logic [31:0] B_Data,
    output logic        B_Gnt,
    input  logic        Clr_Req,
    output logic        Clr_Busy,
    output logic        D_En,
    output logic [4:0]  D_Addr,
    output logic [31:0] D
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [4:0]  sweepAddr_q, sweepAddr_d;
    logic        dEn_q, dEn_d;
    logic [4:0]  dAddr_q, dAddr_d;
    logic [31:0] d_q, d_d;
    logic        aGnt, bGnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            ptr_q       <= 1'b0;
            sweepAddr_q <= 5'd0;
            dEn_q       <= 1'b0;
            dAddr_q     <= 5'd0;
            d_q         <= 32'h0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sweepAddr_q <= sweepAddr_d;
            dEn_q       <= dEn_d;
            dAddr_q     <= dAddr_d;
            d_q         <= d_d;
        end
    end

    // ptr_q == 0 favours A on a tie; writes to register 0 are swallowed
    // but still count as a grant so the requester can move on.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sweepAddr_d = sweepAddr_q;
        dEn_d       = 1'b0;
        dAddr_d     = dAddr_q;
        d_d         = d_q;
        aGnt        = 1'b0;
        bGnt        = 1'b0;
        case (state_q)
            ARB: begin
                if (Clr_Req) begin
                    state_d     = CLEAR;
                    sweepAddr_d = FIRST_CLR_ADDR;
                end else if (A_Req && (!B_Req || !ptr_q)) begin
                    aGnt = 1'b1;
                end else if (B_Req) begin
                    bGnt = 1'b1;
                end
                if (aGnt) begin
                    ptr_d = 1'b1;
                    if (A_Addr != 5'd0) begin
                        dEn_d   = 1'b1;
                        dAddr_d = A_Addr;
                        d_d     = A_Data;
                    end
                end
                if (bGnt) begin
                    ptr_d = 1'b0;
                    if (B_Addr != 5'd0) begin
                        dEn_d   = 1'b1;
                        dAddr_d = B_Addr;
                        d_d     = B_Data;
                    end
                end
            end
            CLEAR: begin
                dEn_d   = 1'b1;
                dAddr_d = sweepAddr_q;
                d_d     = CLR_VALUE;
                if (sweepAddr_q == 5'd31) begin
                    state_d = ARB;
                end else begin
                    sweepAddr_d = sweepAddr_q + 5'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign A_Gnt    = aGnt & ~reset;
    assign B_Gnt    = bGnt & ~reset;
    assign Clr_Busy = (state_q == CLEAR);
    assign D_En     = dEn_q;
    assign D_Addr   = dAddr_q;
    assign D        = d_q;

endmodule
